// File: rtl/clock_period_meter.sv
// Measures the period of a slow asynchronous clock in system-clock cycles,
// flags lock when consecutive periods agree within TOL, and flags loss of edges.
module clock_period_meter #(
    parameter int CNT_W   = 22,
    parameter int TIMEOUT = 2000000,
    parameter int TOL     = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_clk,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [0:0] ST_WAIT_FIRST = 1'b0;
    localparam logic [0:0] ST_MEASURE    = 1'b1;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};

    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        logic [CNT_W-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

    logic             s1_r, s2_r, s3_r;
    logic             rise_s;
    logic [0:0]       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [CNT_W-1:0] period_r, period_nxt_s;
    logic [CNT_W-1:0] meas_len_s;
    logic             tick_r;
    logic             period_valid_r, period_valid_nxt_s;
    logic             locked_r, locked_nxt_s;
    logic             timeout_r, timeout_nxt_s;
    logic             prev_valid_r, prev_valid_nxt_s;

    // Two-flop synchronizer plus history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= in_clk;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Rising edge of the synchronized input.
    always_comb begin
        rise_s     = s2_r & ~s3_r;
        meas_len_s = cnt_r + ONE_C;
    end

    // Next-state logic; period_r doubles as the previous period at each update.
    always_comb begin
        state_nxt_s        = state_r;
        cnt_nxt_s          = cnt_r;
        period_nxt_s       = period_r;
        period_valid_nxt_s = 1'b0;
        locked_nxt_s       = locked_r;
        timeout_nxt_s      = timeout_r;
        prev_valid_nxt_s   = prev_valid_r;
        case (state_r)
            ST_WAIT_FIRST: begin
                if (rise_s) begin
                    state_nxt_s   = ST_MEASURE;
                    cnt_nxt_s     = ZERO_C;
                    timeout_nxt_s = 1'b0;
                end else if (cnt_r == TIMEOUT_C) begin
                    timeout_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + ONE_C;
                end
            end
            ST_MEASURE: begin
                if (rise_s) begin
                    period_nxt_s       = meas_len_s;
                    period_valid_nxt_s = 1'b1;
                    cnt_nxt_s          = ZERO_C;
                    timeout_nxt_s      = 1'b0;
                    prev_valid_nxt_s   = 1'b1;
                    if (prev_valid_r) begin
                        locked_nxt_s = (abs_diff(meas_len_s, period_r) <= TOL_C);
                    end else begin
                        locked_nxt_s = 1'b0;
                    end
                end else if (cnt_r == TIMEOUT_C) begin
                    // Counter stays saturated so WAIT_FIRST keeps timeout asserted.
                    state_nxt_s      = ST_WAIT_FIRST;
                    timeout_nxt_s    = 1'b1;
                    locked_nxt_s     = 1'b0;
                    prev_valid_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r + ONE_C;
                end
            end
            default: begin
                state_nxt_s      = ST_WAIT_FIRST;
                cnt_nxt_s        = ZERO_C;
                locked_nxt_s     = 1'b0;
                prev_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r        <= ST_WAIT_FIRST;
            cnt_r          <= ZERO_C;
            period_r       <= ZERO_C;
            tick_r         <= 1'b0;
            period_valid_r <= 1'b0;
            locked_r       <= 1'b0;
            timeout_r      <= 1'b0;
            prev_valid_r   <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            period_r       <= period_nxt_s;
            tick_r         <= rise_s;
            period_valid_r <= period_valid_nxt_s;
            locked_r       <= locked_nxt_s;
            timeout_r      <= timeout_nxt_s;
            prev_valid_r   <= prev_valid_nxt_s;
        end
    end

    assign tick         = tick_r;
    assign period       = period_r;
    assign period_valid = period_valid_r;
    assign locked       = locked_r;
    assign timeout      = timeout_r;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: table of in_clk periods with per-edge expectations,
// scoreboarded on tick, plus hand sequences for latency, timeout and reset cases.
module tb_clock_period_meter;

    localparam int CNT_W   = 22;
    localparam int TIMEOUT = 50;
    localparam int TOL     = 8;
    localparam int NVEC    = 22;

    typedef struct {
        logic rst;
        int   hi;
        int   lo;
        logic pv;
        int   per;
        logic lk;
        logic to;
    } vec_t;

    typedef struct {
        logic pv;
        int   per;
        logic lk;
        logic to;
    } exp_t;

    logic             clk;
    logic             resetn;
    logic             in_clk;
    logic             tick;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic tick_d = 1'b0;
    vec_t tbl[NVEC];

    clock_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TOL(TOL)) dut (
        .clk(clk),
        .resetn(resetn),
        .in_clk(in_clk),
        .tick(tick),
        .period(period),
        .period_valid(period_valid),
        .locked(locked),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every tick must match the oldest pending expectation.
    always @(negedge clk) begin
        if (resetn && tick) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_tick: tick=1 with no pending edge (t=%0t)", $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("period_valid", int'(period_valid), int'(mon_e.pv));
                chk("period", int'(period), mon_e.per);
                chk("locked", int'(locked), int'(mon_e.lk));
                chk("timeout", int'(timeout), int'(mon_e.to));
            end
        end
        if (period_valid && !tick) begin
            n_vec++;
            n_err++;
            $display("FAIL pv_without_tick: period_valid=1 tick=0 (t=%0t)", $time);
        end
        if (tick && tick_d) begin
            n_vec++;
            n_err++;
            $display("FAIL tick_width: tick high 2 cycles, expected 1 (t=%0t)", $time);
        end
        tick_d <= tick;
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tick"}, int'(tick), 0);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_pv"}, int'(period_valid), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
    endtask

    task automatic do_reset();
        in_clk = 1'b0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        resetn = 1'b1;
    endtask

    task automatic pulse(input int hi, input int lo, input logic pv, input int per,
                         input logic lk, input logic to);
        exp_t x;
        x.pv = pv;
        x.per = per;
        x.lk = lk;
        x.to = to;
        sb_q.push_back(x);
        in_clk = 1'b1;
        repeat (hi) @(negedge clk);
        in_clk = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic push_exp(input logic pv, input int per, input logic lk, input logic to);
        exp_t x;
        x.pv = pv;
        x.per = per;
        x.lk = lk;
        x.to = to;
        sb_q.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Group 1: steady 10, jump to 30, 10/17, and the TOL boundary (diff 8 vs 9).
        tbl[0]  = '{1'b1,  5,  5, 1'b0,  0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0,  5,  5, 1'b1, 10, 1'b0, 1'b0};
        tbl[2]  = '{1'b0,  5,  5, 1'b1, 10, 1'b1, 1'b0};
        tbl[3]  = '{1'b0,  5,  5, 1'b1, 10, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 15, 15, 1'b1, 10, 1'b1, 1'b0};
        tbl[5]  = '{1'b0,  5,  5, 1'b1, 30, 1'b0, 1'b0};
        tbl[6]  = '{1'b0,  5,  5, 1'b1, 10, 1'b0, 1'b0};
        tbl[7]  = '{1'b0,  5, 12, 1'b1, 10, 1'b1, 1'b0};
        tbl[8]  = '{1'b0,  5,  5, 1'b1, 17, 1'b1, 1'b0};
        tbl[9]  = '{1'b0,  5,  6, 1'b1, 10, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 10,  9, 1'b1, 11, 1'b1, 1'b0};
        tbl[11] = '{1'b0,  5,  5, 1'b1, 19, 1'b1, 1'b0};
        tbl[12] = '{1'b0,  5,  5, 1'b1, 10, 1'b0, 1'b0};
        tbl[13] = '{1'b0,  5,  5, 1'b1, 10, 1'b1, 1'b0};
        // Group 2: period 51 (rise meets cnt=TIMEOUT), then 52 (times out first).
        tbl[14] = '{1'b1, 26, 25, 1'b0,  0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 26, 25, 1'b1, 51, 1'b0, 1'b0};
        tbl[16] = '{1'b0,  5,  5, 1'b1, 51, 1'b1, 1'b0};
        tbl[17] = '{1'b0,  5,  5, 1'b1, 10, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 26, 26, 1'b1, 10, 1'b1, 1'b0};
        tbl[19] = '{1'b0,  5,  5, 1'b0, 10, 1'b0, 1'b0};
        tbl[20] = '{1'b0,  5,  5, 1'b1, 10, 1'b0, 1'b0};
        tbl[21] = '{1'b0,  5,  5, 1'b1, 10, 1'b1, 1'b0};

        resetn = 1'b0;
        in_clk = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            if (tbl[i].rst) begin
                do_reset();
            end
            pulse(tbl[i].hi, tbl[i].lo, tbl[i].pv, tbl[i].per, tbl[i].lk, tbl[i].to);
        end

        // Timeout from WAIT_FIRST after reset, then tick latency of a single rise.
        do_reset();
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (timeout) begin
                n = k;
                break;
            end
        end
        chk("wait_first_timeout_delay", n, TIMEOUT + 1);
        push_exp(1'b0, 0, 1'b0, 1'b0);
        in_clk = 1'b1;
        @(negedge clk);
        chk("tick_lat_edge1", int'(tick), 0);
        @(negedge clk);
        chk("tick_lat_edge2", int'(tick), 0);
        @(negedge clk);
        chk("tick_lat_edge3", int'(tick), 1);
        @(negedge clk);
        chk("tick_lat_edge4", int'(tick), 0);
        in_clk = 1'b0;
        repeat (3) @(negedge clk);

        // Lock at 10, stop in_clk, expect timeout 51 cycles after the last tick.
        do_reset();
        pulse(5, 5, 1'b0, 0, 1'b0, 1'b0);
        pulse(5, 5, 1'b1, 10, 1'b0, 1'b0);
        pulse(5, 5, 1'b1, 10, 1'b1, 1'b0);
        push_exp(1'b1, 10, 1'b1, 1'b0);
        in_clk = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tick) break;
        end
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 5) in_clk = 1'b0;
            if (timeout) begin
                n = k;
                break;
            end
        end
        chk("measure_timeout_delay", n, TIMEOUT + 1);
        chk("timeout_locked", int'(locked), 0);
        chk("timeout_period_hold", int'(period), 10);
        pulse(5, 5, 1'b0, 10, 1'b0, 1'b0);

        // Reset mid-period with in_clk high through release.
        do_reset();
        pulse(5, 5, 1'b0, 0, 1'b0, 1'b0);
        pulse(5, 5, 1'b1, 10, 1'b0, 1'b0);
        pulse(5, 5, 1'b1, 10, 1'b1, 1'b0);
        in_clk = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("midreset");
        push_exp(1'b0, 0, 1'b0, 1'b0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        in_clk = 1'b0;
        repeat (6) @(negedge clk);
        pulse(5, 5, 1'b1, 10, 1'b0, 1'b0);
        pulse(5, 5, 1'b1, 10, 1'b1, 1'b0);

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clock_period_meter.md
CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 22, width of the period counter and period output.
REQ-002 SHALL have parameter TIMEOUT, default 2000000, clk cycles without an in_clk rising edge before timeout.
REQ-003 SHALL have parameter TOL, default 8, maximum absolute difference in clk cycles between consecutive periods for lock.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_clk  input  1  slow divided clock, asynchronous to clk.
REQ-007 SHALL have port tick  output  1  one-cycle pulse per detected in_clk rising edge.
REQ-008 SHALL have port period  output  CNT_W  last measured in_clk period in clk cycles.
REQ-009 SHALL have port period_valid  output  1  one-cycle pulse when period updates.
REQ-010 SHALL have port locked  output  1  level; consecutive periods agree within TOL.
REQ-011 SHALL have port timeout  output  1  level; no edge for TIMEOUT cycles.

Function
REQ-012 SHALL pass in_clk through a two-flop synchronizer (s1, s2) plus a history flop s3; rise = s2 AND NOT s3.
REQ-013 SHALL register tick from rise, so tick is high on the 3rd clk rising edge after in_clk is first sampled high, for exactly one cycle.
REQ-014 SHALL implement states WAIT_FIRST (no reference edge) and MEASURE (counting since last edge).
REQ-015 SHALL, in WAIT_FIRST on rise: clear cnt to 0, enter MEASURE, leave period unchanged, not pulse period_valid.
REQ-016 SHALL, in MEASURE with no rise: increment cnt by 1 per cycle, saturating at TIMEOUT.
REQ-017 SHALL, in MEASURE on rise: load period with cnt+1, pulse period_valid the same cycle as tick, clear cnt to 0, store old period as prev_period.
REQ-018 SHALL make period equal to N for an in_clk of exactly N clk cycles per period.
REQ-019 SHALL set locked on a period update where |new period - prev_period| <= TOL and a prev_period from MEASURE exists; clear locked when difference > TOL.
REQ-020 SHALL compute the difference unsigned with no wrap (larger minus smaller).
REQ-021 SHALL, when cnt reaches TIMEOUT in MEASURE without rise: set timeout, clear locked, invalidate prev_period, return to WAIT_FIRST; period holds.
REQ-022 SHALL also set timeout when WAIT_FIRST persists TIMEOUT cycles after reset with no rise.
REQ-023 SHALL clear timeout on the next detected rise.
REQ-024 SHALL give rise priority over timeout when both occur in the same cycle (update as REQ-017, timeout stays 0).
REQ-025 SHALL treat in_clk falling edges and levels as no event.

Reset
REQ-026 SHALL, while resetn=0 at a clk edge: s1=s2=s3=0, cnt=0, state WAIT_FIRST, tick=0, period=0, period_valid=0, locked=0, timeout=0, prev_period invalid.
REQ-027 SHALL abort any measurement on reset mid-period; the first rise after release is a WAIT_FIRST reference edge only.
REQ-028 SHALL recover within one cycle after resetn returns high, independent of in_clk level (in_clk high at release produces one rise after synchronization).

Verification
REQ-029 SHALL verify: in_clk toggles every 5 clk cycles -> first period_valid at second rise with period=10, locked=1 from third rise onward.
REQ-030 SHALL verify: single in_clk rise -> tick exactly 3 clk edges after first sampled high, width 1 cycle.
REQ-031 SHALL verify (TIMEOUT=50): in_clk stops after locking -> timeout=1 and locked=0 at cnt=50, period retains 10; next rise clears timeout with no period_valid.
REQ-032 SHALL verify (TOL=8): periods 10,10,30 -> locked 1 then 0 on the 30 update; periods 10,17 -> locked 1.
REQ-033 SHALL verify: resetn low for 2 cycles mid-period -> all outputs 0; next rise gives no period_valid, the following rise gives the correct period.
REQ-034 SHALL verify (TIMEOUT=50): rise in the same cycle cnt reaches 50 -> period=51, period_valid=1, timeout stays 0.
